noc_ctrl_pkt_arbiter: RTL and testbench

// Parametrised packet arbiter for the NoC control module's debug-out path. It merges
// NUM_SRC packet sources (fault reports, utilisation, future monitors) into one 17-bit

---
 rtl/noc_ctrl_pkt_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_noc_ctrl_pkt_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ctrl_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : noc_ctrl_pkt_arbiter
//  Purpose  : Merges NUM_SRC packet sources into one {last, data[15:0]} flit
//             stream for the debug-out path. Packets are granted atomically
//             (fixed priority or round-robin), lengths are policed at
//             MAX_PKT_LEN (truncate + drop tail), and the result is buffered
//             in a first-word fall-through FIFO.
//  Option   : NCM_ARB_STATS_EN adds per-source packet/truncation counters.
//  Revision : 1.0 - initial release
// ============================================================================
module noc_ctrl_pkt_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DEPTH       = 16,
  parameter int MAX_PKT_LEN = 12,
  parameter int RR_MODE     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0][15:0]   in_data,
  input  logic [NUM_SRC-1:0]         in_last,
  input  logic [NUM_SRC-1:0]         in_valid,
  output logic [NUM_SRC-1:0]         in_ready,
  output logic [15:0]                out_data,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       busy,
  output logic                       trunc_err
`ifdef NCM_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_SRC)-1:0] stat_sel,
  input  logic                       stat_clr,
  output logic [31:0]                stat_pkts,
  output logic [15:0]                stat_trunc
`endif
);

  localparam int IDX_W  = $clog2(NUM_SRC);
  localparam int CNT_W  = $clog2(MAX_PKT_LEN + 1);
  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [IDX_W-1:0] C_TOP_IDX  = IDX_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   ptr_next;
  logic               any_valid;
  logic               sel_valid, sel_last;
  logic               push, push_last, pop, pkt_end, trunc;
  logic               fifo_full;

  logic [16:0]        mem [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [FILL_W-1:0]  fill_q;

  assign any_valid = |in_valid;
  assign sel_valid = in_valid[grant_q];
  assign sel_last  = in_last[grant_q];
  assign ptr_next  = (grant_q == C_TOP_IDX) ? '0 : grant_q + IDX_W'(1);

  // Pick the first requesting source at or after the search base, wrapping.
  always_comb begin : p_arb
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] jj;
    logic             found;
    int               j;
    base   = (RR_MODE != 0) ? ptr_q : '0;
    winner = '0;
    found  = 1'b0;
    jj     = '0;
    j      = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(base) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      jj = IDX_W'(j);
      if (!found && in_valid[jj]) begin
        found  = 1'b1;
        winner = jj;
      end
    end
  end

  // Packet FSM: next state, handshakes, FIFO push and length policing.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    in_ready  = '0;
    push      = 1'b0;
    push_last = 1'b0;
    pkt_end   = 1'b0;
    trunc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        in_ready[grant_q] = ~fifo_full;
        if (sel_valid && !fifo_full) begin
          push  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (sel_last) begin
            push_last = 1'b1;
            pkt_end   = 1'b1;
            ptr_d     = ptr_next;
            state_d   = S_IDLE;
          end else if (cnt_q == C_LAST_CNT) begin
            // Over-long packet: close it here, swallow the rest upstream.
            push_last = 1'b1;
            trunc     = 1'b1;
            state_d   = S_DROP;
          end
        end
      end
      S_DROP: begin
        in_ready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          pkt_end = 1'b1;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, grant, round-robin pointer and flit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign trunc_err = trunc;

  assign fifo_full = (fill_q == FILL_W'(DEPTH));
  assign out_valid = (fill_q != '0);
  assign pop       = out_valid & out_ready;
  assign {out_last, out_data} = mem[rd_q];

  // FIFO pointers and occupancy; push is already gated by fullness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {push_last, in_data[grant_q]};
  end

`ifdef NCM_ARB_STATS_EN
  logic [NUM_SRC-1:0][31:0] stat_pkts_q;
  logic [NUM_SRC-1:0][15:0] stat_trunc_q;

  // Saturating per-source counters; clear has priority over increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts_q  <= '0;
      stat_trunc_q <= '0;
    end else if (stat_clr) begin
      stat_pkts_q  <= '0;
      stat_trunc_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (pkt_end && (grant_q == IDX_W'(s)) && (stat_pkts_q[s] != '1))
          stat_pkts_q[s] <= stat_pkts_q[s] + 32'd1;
        if (trunc && (grant_q == IDX_W'(s)) && (stat_trunc_q[s] != '1))
          stat_trunc_q[s] <= stat_trunc_q[s] + 16'd1;
      end
    end
  end

  assign stat_pkts  = stat_pkts_q[stat_sel];
  assign stat_trunc = stat_trunc_q[stat_sel];
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_ctrl_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_ctrl_pkt_arbiter
//  Purpose  : Scoreboard bench. Two DUTs (fixed priority and round-robin)
//             receive identical packet plans; a per-DUT monitor checks output
//             flits against per-source expected queues and handshake rules.
//  Option   : NCM_ARB_STATS_EN enables the statistics checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noc_ctrl_pkt_arbiter;

  localparam int NS    = 4;
  localparam int DEPTH = 16;
  localparam int MAXL  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit burst     = 1'b1;
  bit stall     = 1'b0;
  bit rnd_ready = 1'b0;

  logic [16:0] src_q [2][NS][$];   // flits each source still has to send
  logic [16:0] exp_q [2][NS][$];   // flits expected at the output, per source
  int          got_order [2][$];
  int          exp_order [2][$];
  int          acc_cnt [2];
  int          trunc_cnt [2];
  bit          in_pkt [2];
  int          cur_src [2];
  int          mptr [2];
  int          seq [NS];
  int          exp_trunc = 0;

`ifdef NCM_ARB_STATS_EN
  logic [1:0] stat_sel = 2'd0;
  logic       stat_clr = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] got);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got=0x%0h expected=nothing", nm, got);
  endtask

  for (genvar gd = 0; gd < 2; gd++) begin : g_dut
    logic [NS-1:0][15:0] in_data;
    logic [NS-1:0]       in_last, in_valid, in_ready;
    logic [15:0]         out_data;
    logic                out_last, out_valid, busy, trunc_err;
    logic                out_ready = 1'b0;
    logic [1:0]          grant_idx;
`ifdef NCM_ARB_STATS_EN
    logic [31:0]         stat_pkts;
    logic [15:0]         stat_trunc;
`endif

    noc_ctrl_pkt_arbiter #(
      .NUM_SRC(NS), .DEPTH(DEPTH), .MAX_PKT_LEN(MAXL), .RR_MODE(gd)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .grant_idx(grant_idx), .busy(busy), .trunc_err(trunc_err)
`ifdef NCM_ARB_STATS_EN
      , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_pkts(stat_pkts), .stat_trunc(stat_trunc)
`endif
    );

    for (genvar gs = 0; gs < NS; gs++) begin : g_src
      logic v = 1'b0, l = 1'b0;
      logic [15:0] dt = '0;
      assign in_valid[gs] = v;
      assign in_last[gs]  = l;
      assign in_data[gs]  = dt;

      // Source: valid/ready producer with random gaps (none before a packet in burst mode).
      initial begin : p_src
        bit pres, hs, lf;
        int gap;
        pres = 1'b0; gap = 0;
        forever begin
          @(negedge clk);
          hs = v & in_ready[gs];
          @(posedge clk); #1;
          if (!rst_n) begin
            src_q[gd][gs].delete();
            pres = 1'b0; gap = 0;
          end else begin
            if (pres && hs) begin
              lf = src_q[gd][gs][0][16];
              void'(src_q[gd][gs].pop_front());
              pres = 1'b0;
              if (lf && burst) gap = 0;
              else gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            if (!pres && src_q[gd][gs].size() > 0) begin
              if (gap > 0) gap--;
              else pres = 1'b1;
            end
          end
          v = pres;
          if (pres) {l, dt} = src_q[gd][gs][0];
          else begin
            l  = 1'($urandom);
            dt = 16'($urandom);
          end
        end
      end
    end

    // Consumer readiness.
    initial begin : p_ordy
      forever begin
        @(posedge clk); #1;
        out_ready = stall ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
    end

    // Monitor: handshake rules and output scoreboard.
    initial begin : p_mon
      bit prev_end, prev_req;
      int s;
      prev_end = 1'b0; prev_req = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk("reset_out_valid", 32'(out_valid), 0);
          chk("reset_busy", 32'(busy), 0);
          chk("reset_in_ready", 32'(in_ready), 0);
          chk("reset_trunc_err", 32'(trunc_err), 0);
          chk("reset_grant_idx", 32'(grant_idx), 0);
          prev_end = 1'b0; prev_req = 1'b0;
        end else begin
          if (prev_end) chk("bubble_after_packet", 32'(busy), 0);
          if (prev_req) chk("arb_latency", 32'(busy), 1);
          if (!busy) chk("idle_in_ready", 32'(in_ready), 0);
          chk("in_ready_onehot", 32'($countones(in_ready) <= 1), 1);
          prev_end = 1'b0;
          for (int k = 0; k < NS; k++) begin
            if (in_valid[k] && in_ready[k]) begin
              chk("grant_idx_on_accept", 32'(grant_idx), k);
              acc_cnt[gd]++;
              if (in_last[k]) prev_end = 1'b1;
            end
          end
          prev_req = !busy && (in_valid != '0);
          if (trunc_err) trunc_cnt[gd]++;
          if (out_valid && out_ready) begin
            s = int'(out_data[15:14]);
            if (in_pkt[gd]) chk("packet_atomic_src", s, cur_src[gd]);
            else begin
              got_order[gd].push_back(s);
              cur_src[gd] = s;
            end
            if (exp_q[gd][s].size() == 0) fail("unexpected_flit", {15'd0, out_last, out_data});
            else chk("out_flit", {15'd0, out_last, out_data}, {15'd0, exp_q[gd][s].pop_front()});
            in_pkt[gd] = !out_last;
          end
        end
      end
    end
  end

  // Queue one packet of n flits from source s to both DUTs, with its expected
  // output: at most MAXL flits, the MAXL-th closing an over-long packet.
  task automatic send_pkt(input int s, input int n);
    logic [16:0] f;
    for (int d = 0; d < 2; d++) begin
      for (int i = 1; i <= n; i++) begin
        f = {1'b0, 2'(s), 6'(seq[s]), 8'(i)};
        f[16] = (i == n);
        src_q[d][s].push_back(f);
        if (i <= MAXL) begin
          f[16] = (i == n) || (i == MAXL);
          exp_q[d][s].push_back(f);
        end
      end
    end
    if (n > MAXL) exp_trunc++;
    seq[s]++;
  endtask

  // Expected packet order when every source keeps requesting until its packets are done.
  task automatic model_order(input int c0, input int c1, input int c2, input int c3);
    int cnt[NS];
    int total, pick, idx;
    for (int d = 0; d < 2; d++) begin
      cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
      total = c0 + c1 + c2 + c3;
      exp_order[d].delete();
      got_order[d].delete();
      while (total > 0) begin
        pick = -1;
        for (int k = 0; k < NS; k++) begin
          idx = (d == 1) ? (mptr[d] + k) % NS : k;
          if (pick < 0 && cnt[idx] > 0) pick = idx;
        end
        exp_order[d].push_back(pick);
        cnt[pick]--;
        total--;
        mptr[d] = (pick + 1) % NS;
      end
    end
  endtask

  task automatic cmp_order();
    for (int d = 0; d < 2; d++) begin
      chk("grant_order_len", got_order[d].size(), exp_order[d].size());
      for (int i = 0; i < exp_order[d].size() && i < got_order[d].size(); i++)
        chk("grant_order", got_order[d][i], exp_order[d][i]);
    end
  endtask

  task automatic drain(input string nm);
    int t;
    bit pend;
    t = 0;
    forever begin
      pend = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < NS; s++)
          if (src_q[d][s].size() != 0 || exp_q[d][s].size() != 0) pend = 1'b1;
      if (!pend) break;
      if (t >= 5000) begin
        fail({nm, "_drain_timeout"}, t);
        break;
      end
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) chk({nm, "_packet_closed"}, 32'(in_pkt[d]), 0);
  endtask

  // Assert reset now, check the asynchronous clear, hold three cycles, release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid0", 32'(g_dut[0].out_valid), 0);
    chk("async_reset_busy0", 32'(g_dut[0].busy), 0);
    chk("async_reset_out_valid1", 32'(g_dut[1].out_valid), 0);
    chk("async_reset_busy1", 32'(g_dut[1].busy), 0);
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < NS; s++) exp_q[d][s].delete();
      got_order[d].delete();
      in_pkt[d] = 1'b0;
      mptr[d]   = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : p_main
    int base [2];
    int t;
    #1;
    do_reset();

    // Two simultaneous 3-flit packets from sources 0 and 2.
    burst = 1'b1; rnd_ready = 1'b0;
    model_order(1, 0, 1, 0);
    send_pkt(0, 3);
    send_pkt(2, 3);
    drain("two_src");
    cmp_order();

    // All sources requesting continuously from a fresh pointer.
    @(posedge clk); #2;
    do_reset();
    model_order(2, 1, 1, 1);
    send_pkt(0, $urandom_range(2, 5));
    send_pkt(0, $urandom_range(2, 5));
    for (int s = 1; s < NS; s++) send_pkt(s, $urandom_range(2, 5));
    drain("all_src");
    cmp_order();

    // Over-long packet: 15 flits from source 1.
    rnd_ready = 1'b1;
    for (int d = 0; d < 2; d++) base[d] = trunc_cnt[d];
    send_pkt(1, 15);
    drain("truncate");
    for (int d = 0; d < 2; d++) chk("trunc_pulse_once", trunc_cnt[d] - base[d], 1);

    // Consumer stalled with a 20-flit backlog: exactly DEPTH flits accepted.
    rnd_ready = 1'b0; stall = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) base[d] = acc_cnt[d];
    send_pkt(0, 10);
    send_pkt(1, 10);
    repeat (120) @(posedge clk);
    @(negedge clk); #1;
    chk("full_accepted0", acc_cnt[0] - base[0], DEPTH);
    chk("full_accepted1", acc_cnt[1] - base[1], DEPTH);
    chk("full_in_ready0", 32'(g_dut[0].in_ready), 0);
    chk("full_in_ready1", 32'(g_dut[1].in_ready), 0);
    chk("full_out_valid0", 32'(g_dut[0].out_valid), 1);
    stall = 1'b0;
    drain("backpressure");

    // Randomized traffic: random sources, lengths, gaps and consumer stalls.
    burst = 1'b0; rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_pkt($urandom_range(0, NS - 1), $urandom_range(1, 15));
      repeat ($urandom_range(0, 8)) @(posedge clk);
      #2;
    end
    drain("random");

    // Reset during flit 2 of a 5-flit packet, then a clean packet.
    burst = 1'b1; rnd_ready = 1'b0;
    @(posedge clk); #2;
    base[0] = acc_cnt[0];
    send_pkt(2, 5);
    t = 0;
    while (acc_cnt[0] - base[0] < 2 && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 200) fail("midpkt_wait_timeout", t);
    do_reset();
    send_pkt(2, 4);
    drain("after_reset");

`ifdef NCM_ARB_STATS_EN
    send_pkt(3, 4);
    send_pkt(3, 14);
    drain("stats");
    stat_sel = 2'd3;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("stat_pkts_src3", d == 0 ? g_dut[0].stat_pkts : g_dut[1].stat_pkts, 2);
      chk("stat_trunc_src3", d == 0 ? 32'(g_dut[0].stat_trunc) : 32'(g_dut[1].stat_trunc), 1);
    end
    stat_sel = 2'd2;
    #1;
    chk("stat_pkts_src2", g_dut[0].stat_pkts, 1);
    @(posedge clk); #2;
    stat_clr = 1'b1;
    @(posedge clk); #2;
    stat_clr = 1'b0;
    stat_sel = 2'd3;
    #1;
    chk("stat_pkts_cleared", g_dut[1].stat_pkts, 0);
    chk("stat_trunc_cleared", 32'(g_dut[1].stat_trunc), 0);
`endif

    for (int d = 0; d < 2; d++) chk("trunc_total", trunc_cnt[d], exp_trunc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
